// File: rtl/uart_tx.sv
// UART transmit engine: start bit, LSB-first data, optional parity, one stop bit.
// One serial bit per Clk cycle; TX_OUT and Busy are registered.
module uart_tx #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  TX_OUT,
    output logic                  Busy
);

    localparam int CW = $clog2(DATA_WIDTH) + 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [CW-1:0]         bit_cnt;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  par_en_q;
    logic                  par_bit;
    logic                  tx_next;
    logic                  busy_next;
    logic                  accept;
    logic                  last_bit;

    assign accept   = (state == IDLE) && Data_Valid;
    assign last_bit = (bit_cnt == CW'(DATA_WIDTH - 1));

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state  <= IDLE;
            TX_OUT <= 1'b1;
            Busy   <= 1'b0;
        end else begin
            state  <= state_next;
            TX_OUT <= tx_next;
            Busy   <= busy_next;
        end
    end

    // Outputs are computed for the state being entered, so the line
    // changes on the same edge as the state.
    always_comb begin
        state_next = state;
        tx_next    = 1'b1;
        busy_next  = 1'b1;
        case (state)
            IDLE: begin
                busy_next = 1'b0;
                if (Data_Valid) begin
                    state_next = START;
                    tx_next    = 1'b0;
                    busy_next  = 1'b1;
                end
            end
            START: begin
                state_next = DATA;
                tx_next    = data_q[0];
            end
            DATA: begin
                if (!last_bit) begin
                    tx_next = data_q[0];
                end else if (par_en_q) begin
                    state_next = PARITY;
                    tx_next    = par_bit;
                end else begin
                    state_next = STOP;
                end
            end
            PARITY: begin
                state_next = STOP;
            end
            STOP: begin
                state_next = IDLE;
                busy_next  = 1'b0;
            end
            default: begin
                state_next = IDLE;
                busy_next  = 1'b0;
            end
        endcase
    end

    // The latch shifts right as bits go out; bit 0 is always the next data bit.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            bit_cnt  <= '0;
            data_q   <= '0;
            par_en_q <= 1'b0;
            par_bit  <= 1'b0;
        end else if (accept) begin
            bit_cnt  <= '0;
            data_q   <= P_DATA;
            par_en_q <= PAR_EN;
            par_bit  <= (^P_DATA) ^ PAR_TYP;
        end else if (state == START) begin
            data_q <= data_q >> 1;
        end else if (state == DATA && !last_bit) begin
            data_q  <= data_q >> 1;
            bit_cnt <= bit_cnt + CW'(1);
        end
    end

endmodule
